wall_column_buffer: RTL and testbench

- Producer-side counterpart to the colour mapper's `wall_on`/`wall_color` inputs.
- Accepts one wall slice per screen column from the ray-caster over a valid/ready handshake.
- Stores slices in a ping-pong column buffer. Banks swap only at frame boundaries, so a frame is never torn.
- Answers per-pixel queries (`DrawX`, `DrawY`) with `wall_on`/`wall_color` at fixed latency, in the pixel-clock domain.

---
 rtl/wall_column_buffer.sv | 130 +++++++++++++
 tb/tb_wall_column_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wall_column_buffer.sv
// Ping-pong column buffer between the ray-caster and the colour mapper.
// Slices are written into one bank while the other is scanned out per pixel.
module wall_column_buffer #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int HEIGHT_W = 9,
    parameter int COLOR_W  = 12
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                col_valid,
    output logic                col_ready,
    input  logic [9:0]          col_x,
    input  logic [HEIGHT_W-1:0] col_height,
    input  logic [COLOR_W-1:0]  col_color,
    input  logic                col_last,
    input  logic                frame_start,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic                wall_on,
    output logic [COLOR_W-1:0]  wall_color,
    output logic [7:0]          frame_drops
);
    localparam int ENT_W = HEIGHT_W + COLOR_W;
    localparam logic [9:0] H_LIM = 10'(H_RES);
    localparam logic [9:0] V_LIM = 10'(V_RES);

    typedef enum logic {FILL, DONE} state_t;

    state_t state, state_nx;
    logic   live;
    logic   wr_bank, wr_bank_nx;
    logic   disp_bank;
    logic   disp_valid, disp_valid_nx;
    logic   drop_inc;
    logic   xfer;

    logic [ENT_W-1:0]    mem [0:2047];
    logic [ENT_W-1:0]    ent_p1;
    logic [9:0]          x_p1, y_p1;
    logic                vld_p1;
    logic [HEIGHT_W-1:0] h_p1;
    logic [9:0]          top_p1, bot_p1;
    logic                on_p1;

    function automatic logic [HEIGHT_W-1:0] clamp_height(input logic [HEIGHT_W-1:0] h);
        if (32'(h) > V_RES)
            return HEIGHT_W'(V_RES);
        return h;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign col_ready = live && (state == FILL);
    assign xfer      = col_valid && col_ready;
    assign disp_bank = ~wr_bank;

    always_comb begin
        state_nx      = state;
        wr_bank_nx    = wr_bank;
        disp_valid_nx = disp_valid;
        drop_inc      = 1'b0;
        case (state)
            FILL: begin
                if (xfer && col_last)
                    state_nx = DONE;
                if (frame_start)
                    drop_inc = 1'b1;
            end
            DONE: begin
                if (frame_start) begin
                    wr_bank_nx    = ~wr_bank;
                    disp_valid_nx = 1'b1;
                    state_nx      = FILL;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= FILL;
            live        <= 1'b0;
            wr_bank     <= 1'b0;
            disp_valid  <= 1'b0;
            frame_drops <= 8'd0;
        end else begin
            state      <= state_nx;
            live       <= 1'b1;
            wr_bank    <= wr_bank_nx;
            disp_valid <= disp_valid_nx;
            if (drop_inc)
                frame_drops <= sat_inc(frame_drops);
        end
    end

    // Stage 0 -> 1: RAM write port and synchronous read of the displayed bank
    always_ff @(posedge Clk) begin
        if (xfer && (col_x < H_LIM))
            mem[{wr_bank, col_x}] <= {clamp_height(col_height), col_color};
        ent_p1 <= mem[{disp_bank, DrawX}];
        x_p1   <= DrawX;
        y_p1   <= DrawY;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= disp_valid;
    end

    // Stage 1 -> 2: vertical span of the slice, odd heights round the top down
    assign h_p1   = ent_p1[ENT_W-1:COLOR_W];
    assign top_p1 = (V_LIM - 10'(h_p1)) >> 1;
    assign bot_p1 = top_p1 + 10'(h_p1);
    assign on_p1  = vld_p1 && (x_p1 < H_LIM) && (y_p1 >= top_p1) && (y_p1 < bot_p1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wall_on    <= 1'b0;
            wall_color <= '0;
        end else begin
            wall_on    <= on_p1;
            wall_color <= on_p1 ? ent_p1[COLOR_W-1:0] : '0;
        end
    end
endmodule

// File: tb/tb_wall_column_buffer.sv
// Directed bench for wall_column_buffer with a per-frame bank model and literal spot checks.
module tb_wall_column_buffer;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        col_valid = 1'b0;
    logic        col_ready;
    logic [9:0]  col_x = '0;
    logic [8:0]  col_height = '0;
    logic [11:0] col_color = '0;
    logic        col_last = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0;
    logic [9:0]  DrawY = '0;
    logic        wall_on;
    logic [11:0] wall_color;
    logic [7:0]  frame_drops;

    int checks = 0;
    int failures = 0;

    wall_column_buffer dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .col_valid(col_valid), .col_ready(col_ready),
        .col_x(col_x), .col_height(col_height), .col_color(col_color),
        .col_last(col_last), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY),
        .wall_on(wall_on), .wall_color(wall_color), .frame_drops(frame_drops)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two banks of {height,colour}, frame-level FSM flags, 2-deep output delay
    int m_h [2][640];
    int m_c [2][640];
    int m_wr = 0, m_dv = 0, m_fill = 1, m_live = 0, m_drops = 0;
    int e_on = 0, e_col = 0, p_on = 0, p_col = 0;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_wr = 0; m_dv = 0; m_fill = 1; m_live = 0; m_drops = 0;
            e_on = 0; e_col = 0; p_on = 0; p_col = 0;
        end else begin
            int h, top, old_fill;
            e_on = p_on; e_col = p_col;
            p_on = 0; p_col = 0;
            if (m_dv != 0 && DrawX < 640) begin
                h   = m_h[1 - m_wr][DrawX];
                top = (480 - h) / 2;
                if (DrawY >= top && DrawY < top + h) begin
                    p_on  = 1;
                    p_col = m_c[1 - m_wr][DrawX];
                end
            end
            old_fill = m_fill;
            if (col_valid && m_fill != 0 && m_live != 0) begin
                if (col_x < 640) begin
                    m_h[m_wr][col_x] = (col_height > 480) ? 480 : int'(col_height);
                    m_c[m_wr][col_x] = col_color;
                end
                if (col_last) m_fill = 0;
            end
            if (frame_start) begin
                if (old_fill != 0) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    m_wr = 1 - m_wr; m_dv = 1; m_fill = 1;
                end
            end
            m_live = 1;
        end
    end

    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("wall_on", wall_on, e_on);
            chk("wall_color", wall_color, e_col);
            chk("col_ready", col_ready, (m_fill != 0 && m_live != 0) ? 1 : 0);
            chk("frame_drops", frame_drops, m_drops);
        end
    end

    task automatic send(input int x, input int h, input int c, input bit last);
        bit r;
        col_valid = 1'b1; col_x = 10'(x); col_height = 9'(h); col_color = 12'(c); col_last = last;
        for (int i = 0; i < 50; i++) begin
            r = col_ready;
            @(negedge Clk);
            if (r) begin
                col_valid = 1'b0; col_last = 1'b0;
                return;
            end
        end
        col_valid = 1'b0; col_last = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic query(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        DrawX = 10'd100; DrawY = 10'd240;
        repeat (2) @(negedge Clk);
        chk("rst_ready", col_ready, 0);
        chk("rst_wall_on", wall_on, 0);
        #3 Reset_n = 1'b1;
        #1 chk("ready_before_edge", col_ready, 0);
        @(negedge Clk);
        chk("ready_after_edge", col_ready, 1);
        repeat (5) @(negedge Clk);
        chk("no_write_wall_on", wall_on, 0);

        send(101, 0, 12'h000, 0);
        send(100, 80, 12'hF00, 1);
        pulse_fs();
        query(100, 199); chk("y199_off", wall_on, 0);
        DrawY = 10'd200;
        @(negedge Clk); chk("lat1_still_off", wall_on, 0);
        @(negedge Clk); chk("lat2_on", wall_on, 1); chk("lat2_color", wall_color, 12'hF00);
        query(100, 279); chk("y279_on", wall_on, 1);
        query(100, 280); chk("y280_off", wall_on, 0); chk("y280_color", wall_color, 0);
        for (int y = 0; y < 480; y++) begin DrawY = 10'(y); @(negedge Clk); end
        query(101, 240); chk("x101_off", wall_on, 0);

        send(5, 511, 12'h0F0, 0);
        send(700, 50, 12'hABC, 0);
        chk("ready_after_700", col_ready, 1);
        DrawX = 10'd100; DrawY = 10'd240;
        repeat (3) pulse_fs();
        @(negedge Clk);
        chk("drops3", frame_drops, 3);
        chk("disp_unchanged", wall_on, 1);

        send(6, 5, 12'h00F, 1);
        col_valid = 1'b1; col_x = 10'd5; col_height = 9'd10; col_color = 12'h111;
        repeat (4) @(negedge Clk);
        chk("done_not_ready", col_ready, 0);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        chk("ready_after_swap", col_ready, 1);
        @(negedge Clk);
        col_valid = 1'b0;
        DrawX = 10'd5;
        for (int y = 0; y < 480; y++) begin DrawY = 10'(y); @(negedge Clk); end
        query(5, 0);   chk("clamp_y0", wall_on, 1);
        query(5, 479); chk("clamp_y479", wall_on, 1); chk("clamp_color", wall_color, 12'h0F0);
        query(6, 236); chk("h5_236", wall_on, 0);
        query(6, 237); chk("h5_237", wall_on, 1);
        query(6, 241); chk("h5_241", wall_on, 1);
        query(6, 242); chk("h5_242", wall_on, 0);

        frame_start = 1'b1;
        send(7, 100, 12'h777, 1);
        frame_start = 1'b0;
        chk("same_cycle_drop", frame_drops, 4);
        chk("same_cycle_done", col_ready, 0);
        query(5, 240); chk("still_old_bank", wall_on, 1);
        pulse_fs();
        query(7, 190); chk("x7_y190", wall_on, 1); chk("x7_color", wall_color, 12'h777);
        query(7, 189); chk("x7_y189", wall_on, 0);
        query(5, 235); chk("x5_h10_on", wall_color, 12'h111);
        query(5, 245); chk("x5_h10_off", wall_on, 0);

        repeat (300) pulse_fs();
        @(negedge Clk);
        chk("drops_sat", frame_drops, 255);

        query(7, 200); chk("pre_reset_on", wall_on, 1);
        col_valid = 1'b1; col_x = 10'd8; col_height = 9'd40; col_color = 12'h222;
        #2 Reset_n = 1'b0;
        #1 chk("async_wall_on", wall_on, 0);
        chk("async_color", wall_color, 0);
        chk("async_ready", col_ready, 0);
        chk("async_drops", frame_drops, 0);
        repeat (2) @(negedge Clk);
        col_valid = 1'b0;
        #3 Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        chk("post_reset_hidden", wall_on, 0);
        chk("post_reset_ready", col_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
